// File: rtl/corefifo_rd_ptr_ctrl_if.sv
// Read-side bus of the dual-clock FIFO: consumer request, synchronized write
// pointer, RAM read port and status flags.
interface corefifo_rd_ptr_ctrl_if #(
    parameter int ADDRWIDTH = 3
);
    logic                 re;
    logic [ADDRWIDTH:0]   wptr_gray_sync;
    logic [ADDRWIDTH-1:0] raddr;
    logic                 mem_re;
    logic [ADDRWIDTH:0]   rptr_gray;
    logic                 empty;
    logic                 aempty;
    logic [ADDRWIDTH:0]   rd_count;
    logic                 dvld;
    logic                 underflow;
    logic                 ptr_err;

    modport slave (
        input  re, wptr_gray_sync,
        output raddr, mem_re, rptr_gray, empty, aempty, rd_count, dvld,
               underflow, ptr_err
    );

    modport master (
        output re, wptr_gray_sync,
        input  raddr, mem_re, rptr_gray, empty, aempty, rd_count, dvld,
               underflow, ptr_err
    );
endinterface

// File: rtl/corefifo_rd_ptr_ctrl.sv
// Read-side pointer/flag controller of the dual-clock FIFO (read clock domain).
// Define COREFIFO_RD_FWFT_EN for the first-word-fall-through output sequencer.
//
// state      | meaning (FWFT build only)
// S_EMPTY    | no word at output, fetch as soon as RAM is non-empty
// S_PREFETCH | RAM read issued, word lands at output next edge
// S_VALID    | word at output (dvld=1), refetch on re without bubble
module corefifo_rd_ptr_ctrl #(
    parameter int ADDRWIDTH = 3,
    parameter int AE_LEVEL  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    corefifo_rd_ptr_ctrl_if.slave bus
);
    localparam int PW = ADDRWIDTH + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDRWIDTH{1'b0}}};
    localparam logic [PW-1:0] AE    = AE_LEVEL[PW-1:0];

    logic [PW-1:0] r_rbin;
    logic [PW-1:0] r_rptr_gray;
    logic          r_empty;
    logic          r_aempty;
    logic [PW-1:0] r_rd_count;
    logic          r_underflow;
    logic          r_ptr_err;

    logic [PW-1:0] w_wbin;
    logic [PW-1:0] w_rbin_next;
    logic [PW-1:0] w_rnext_gray;
    logic [PW-1:0] w_diff;
    logic          w_mem_re;
    logic          w_dvld;
    logic          w_empty_out;
    logic          w_uflow;

    always_comb begin
        w_wbin         = '0;
        w_wbin[PW-1]   = bus.wptr_gray_sync[PW-1];
        for (int i = PW - 1; i > 0; i--)
            w_wbin[i-1] = w_wbin[i] ^ bus.wptr_gray_sync[i-1];
    end

    assign w_rbin_next  = r_rbin + {{ADDRWIDTH{1'b0}}, w_mem_re};
    assign w_rnext_gray = w_rbin_next ^ (w_rbin_next >> 1);
    assign w_diff       = w_wbin - w_rbin_next;

    // Flags use rbin_next so the last read and empty land on the same edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rbin      <= '0;
            r_rptr_gray <= '0;
            r_empty     <= 1'b1;
            r_aempty    <= 1'b1;
            r_rd_count  <= '0;
            r_underflow <= 1'b0;
            r_ptr_err   <= 1'b0;
        end else begin
            r_rbin      <= w_rbin_next;
            r_rptr_gray <= w_rnext_gray;
            r_empty     <= (w_rnext_gray == bus.wptr_gray_sync);
            r_aempty    <= (w_diff <= AE);
            r_rd_count  <= w_diff;
            r_underflow <= w_uflow;
            r_ptr_err   <= r_ptr_err | (w_diff > DEPTH);
        end
    end

`ifdef COREFIFO_RD_FWFT_EN
    typedef enum logic [1:0] {S_EMPTY, S_PREFETCH, S_VALID} state_t;
    state_t r_state, w_state_next;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= S_EMPTY;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_mem_re     = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (!r_empty) begin
                    w_mem_re     = 1'b1;
                    w_state_next = S_PREFETCH;
                end
            end
            S_PREFETCH: w_state_next = S_VALID;
            S_VALID: begin
                if (bus.re && !r_empty) w_mem_re = 1'b1;
                else if (bus.re)        w_state_next = S_EMPTY;
            end
            default: w_state_next = S_EMPTY;
        endcase
    end

    assign w_dvld      = (r_state == S_VALID);
    assign w_empty_out = ~w_dvld;
    assign w_uflow     = bus.re & ~w_dvld;
`else
    logic r_dvld;

    assign w_mem_re = bus.re & ~r_empty;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_dvld <= 1'b0;
        else         r_dvld <= w_mem_re;
    end

    assign w_dvld      = r_dvld;
    assign w_empty_out = r_empty;
    assign w_uflow     = bus.re & r_empty;
`endif

    assign bus.raddr     = r_rbin[ADDRWIDTH-1:0];
    assign bus.mem_re    = w_mem_re;
    assign bus.rptr_gray = r_rptr_gray;
    assign bus.empty     = w_empty_out;
    assign bus.aempty    = r_aempty;
    assign bus.rd_count  = r_rd_count;
    assign bus.dvld      = w_dvld;
    assign bus.underflow = r_underflow;
    assign bus.ptr_err   = r_ptr_err;
endmodule

// File: tb/tb_corefifo_rd_ptr_ctrl.sv
// Directed self-checking bench for corefifo_rd_ptr_ctrl (ADDRWIDTH=3, AE_LEVEL=1).
module tb_corefifo_rd_ptr_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    corefifo_rd_ptr_ctrl_if #(.ADDRWIDTH(3)) bus ();

    corefifo_rd_ptr_ctrl #(.ADDRWIDTH(3), .AE_LEVEL(1)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    function automatic logic [3:0] gray(input int b);
        logic [3:0] t;
        t = 4'(b);
        return t ^ (t >> 1);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        bus.re = 1'b0;
        bus.wptr_gray_sync = 4'd0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.re = 1'b0;
        bus.wptr_gray_sync = 4'd0;
        rst = 1'b1;
        #12;
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", bus.empty); else n_pass++;
        n_checks++; if (bus.aempty !== 1'b1) $display("FAIL reset_aempty got=%b exp=1", bus.aempty); else n_pass++;
        n_checks++; if (bus.rd_count !== 4'd0) $display("FAIL reset_rd_count got=%0d exp=0", bus.rd_count); else n_pass++;
        n_checks++; if (bus.rptr_gray !== 4'd0) $display("FAIL reset_rptr_gray got=%0d exp=0", bus.rptr_gray); else n_pass++;
        n_checks++; if (bus.raddr !== 3'd0) $display("FAIL reset_raddr got=%0d exp=0", bus.raddr); else n_pass++;
        n_checks++; if (bus.ptr_err !== 1'b0) $display("FAIL reset_ptr_err got=%b exp=0", bus.ptr_err); else n_pass++;
        n_checks++; if (bus.dvld !== 1'b0) $display("FAIL reset_dvld got=%b exp=0", bus.dvld); else n_pass++;
        n_checks++; if (bus.underflow !== 1'b0) $display("FAIL reset_underflow got=%b exp=0", bus.underflow); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL reset_release_empty got=%b exp=1", bus.empty); else n_pass++;
    endtask

`ifndef COREFIFO_RD_FWFT_EN
    task automatic test_fill_drain();
        int steps [5] = '{0, 1, 3, 2, 6};
        int exp_gray [4] = '{1, 3, 2, 6};
        do_reset();
        foreach (steps[i]) begin
            bus.wptr_gray_sync = 4'(steps[i]);
            @(negedge clk);
        end
        n_checks++; if (bus.empty !== 1'b0) $display("FAIL fill_empty got=%b exp=0", bus.empty); else n_pass++;
        n_checks++; if (bus.aempty !== 1'b0) $display("FAIL fill_aempty got=%b exp=0", bus.aempty); else n_pass++;
        n_checks++; if (bus.rd_count !== 4'd4) $display("FAIL fill_rd_count got=%0d exp=4", bus.rd_count); else n_pass++;
        bus.re = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++; if (bus.mem_re !== 1'b1) $display("FAIL drain_mem_re[%0d] got=%b exp=1", k, bus.mem_re); else n_pass++;
            n_checks++; if (bus.raddr !== 3'(k)) $display("FAIL drain_raddr[%0d] got=%0d exp=%0d", k, bus.raddr, k); else n_pass++;
            n_checks++; if (bus.dvld !== (k != 0)) $display("FAIL drain_dvld[%0d] got=%b exp=%b", k, bus.dvld, (k != 0)); else n_pass++;
            @(negedge clk);
            n_checks++; if (bus.rptr_gray !== 4'(exp_gray[k])) $display("FAIL drain_rptr_gray[%0d] got=%0d exp=%0d", k, bus.rptr_gray, exp_gray[k]); else n_pass++;
        end
        #1;
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL drain_empty got=%b exp=1", bus.empty); else n_pass++;
        n_checks++; if (bus.mem_re !== 1'b0) $display("FAIL drain_mem_re_5th got=%b exp=0", bus.mem_re); else n_pass++;
        n_checks++; if (bus.dvld !== 1'b1) $display("FAIL drain_dvld_last got=%b exp=1", bus.dvld); else n_pass++;
        n_checks++; if (bus.aempty !== 1'b1) $display("FAIL drain_aempty got=%b exp=1", bus.aempty); else n_pass++;
        @(negedge clk);
        bus.re = 1'b0;
        n_checks++; if (bus.dvld !== 1'b0) $display("FAIL drain_dvld_end got=%b exp=0", bus.dvld); else n_pass++;
        n_checks++; if (bus.underflow !== 1'b1) $display("FAIL drain_underflow got=%b exp=1", bus.underflow); else n_pass++;
        n_checks++; if (bus.rd_count !== 4'd0) $display("FAIL drain_rd_count got=%0d exp=0", bus.rd_count); else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.wptr_gray_sync = gray(i + 1);
            @(negedge clk);
            n_checks++; if (bus.rd_count !== 4'd1) $display("FAIL wrap_rd_count[%0d] got=%0d exp=1", i, bus.rd_count); else n_pass++;
            bus.re = 1'b1;
            #1;
            n_checks++; if (bus.raddr !== 3'(i)) $display("FAIL wrap_raddr[%0d] got=%0d exp=%0d", i, bus.raddr, i % 8); else n_pass++;
            @(negedge clk);
            bus.re = 1'b0;
            n_checks++; if (bus.rptr_gray !== gray(i + 1)) $display("FAIL wrap_rptr_gray[%0d] got=%0d exp=%0d", i, bus.rptr_gray, gray(i + 1)); else n_pass++;
            n_checks++; if (bus.empty !== 1'b1) $display("FAIL wrap_empty[%0d] got=%b exp=1", i, bus.empty); else n_pass++;
        end
        n_checks++; if (bus.rptr_gray !== 4'd0) $display("FAIL wrap_rptr_zero got=%0d exp=0", bus.rptr_gray); else n_pass++;
        bus.wptr_gray_sync = gray(8);
        @(negedge clk);
        n_checks++; if (bus.rd_count !== 4'd8) $display("FAIL wrap_full_count got=%0d exp=8", bus.rd_count); else n_pass++;
        n_checks++; if (bus.aempty !== 1'b0) $display("FAIL wrap_full_aempty got=%b exp=0", bus.aempty); else n_pass++;
        n_checks++; if (bus.ptr_err !== 1'b0) $display("FAIL wrap_full_ptr_err got=%b exp=0", bus.ptr_err); else n_pass++;
    endtask

    task automatic test_underflow();
        do_reset();
        bus.re = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (bus.mem_re !== 1'b0) $display("FAIL uflow_mem_re[%0d] got=%b exp=0", k, bus.mem_re); else n_pass++;
            @(negedge clk);
            n_checks++; if (bus.underflow !== 1'b1) $display("FAIL uflow_pulse[%0d] got=%b exp=1", k, bus.underflow); else n_pass++;
            n_checks++; if (bus.rptr_gray !== 4'd0) $display("FAIL uflow_rptr[%0d] got=%0d exp=0", k, bus.rptr_gray); else n_pass++;
        end
        bus.re = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.underflow !== 1'b0) $display("FAIL uflow_clear got=%b exp=0", bus.underflow); else n_pass++;
        bus.wptr_gray_sync = gray(12);
        @(negedge clk);
        n_checks++; if (bus.ptr_err !== 1'b1) $display("FAIL ptr_err_set got=%b exp=1", bus.ptr_err); else n_pass++;
        bus.wptr_gray_sync = 4'd0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.ptr_err !== 1'b1) $display("FAIL ptr_err_sticky got=%b exp=1", bus.ptr_err); else n_pass++;
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL ptr_err_empty got=%b exp=1", bus.empty); else n_pass++;
        do_reset();
        n_checks++; if (bus.ptr_err !== 1'b0) $display("FAIL ptr_err_reset got=%b exp=0", bus.ptr_err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.wptr_gray_sync = gray(7);
        @(negedge clk);
        bus.re = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.rd_count !== 4'd5) $display("FAIL mid_rd_count got=%0d exp=5", bus.rd_count); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.rd_count !== 4'd0) $display("FAIL mid_rst_count got=%0d exp=0", bus.rd_count); else n_pass++;
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL mid_rst_empty got=%b exp=1", bus.empty); else n_pass++;
        n_checks++; if (bus.dvld !== 1'b0) $display("FAIL mid_rst_dvld got=%b exp=0", bus.dvld); else n_pass++;
        n_checks++; if (bus.raddr !== 3'd0) $display("FAIL mid_rst_raddr got=%0d exp=0", bus.raddr); else n_pass++;
        n_checks++; if (bus.rptr_gray !== 4'd0) $display("FAIL mid_rst_rptr got=%0d exp=0", bus.rptr_gray); else n_pass++;
        n_checks++; if (bus.mem_re !== 1'b0) $display("FAIL mid_rst_mem_re got=%b exp=0", bus.mem_re); else n_pass++;
        bus.re = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.rd_count !== 4'd7) $display("FAIL mid_resume_count got=%0d exp=7", bus.rd_count); else n_pass++;
        bus.re = 1'b1;
        #1;
        n_checks++; if (bus.mem_re !== 1'b1) $display("FAIL mid_resume_mem_re got=%b exp=1", bus.mem_re); else n_pass++;
        @(negedge clk);
        bus.re = 1'b0;
        n_checks++; if (bus.rptr_gray !== 4'd1) $display("FAIL mid_resume_rptr got=%0d exp=1", bus.rptr_gray); else n_pass++;
        n_checks++; if (bus.rd_count !== 4'd6) $display("FAIL mid_resume_count2 got=%0d exp=6", bus.rd_count); else n_pass++;
        n_checks++; if (bus.dvld !== 1'b1) $display("FAIL mid_resume_dvld got=%b exp=1", bus.dvld); else n_pass++;
    endtask
`else
    task automatic test_fwft();
        do_reset();
        bus.wptr_gray_sync = gray(1);
        @(negedge clk);
        #1;
        n_checks++; if (bus.dvld !== 1'b0) $display("FAIL fwft_dvld_n1 got=%b exp=0", bus.dvld); else n_pass++;
        n_checks++; if (bus.mem_re !== 1'b1) $display("FAIL fwft_mem_re_n1 got=%b exp=1", bus.mem_re); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.dvld !== 1'b0) $display("FAIL fwft_dvld_n2 got=%b exp=0", bus.dvld); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus.dvld !== 1'b1) $display("FAIL fwft_dvld_n3 got=%b exp=1", bus.dvld); else n_pass++;
        n_checks++; if (bus.empty !== 1'b0) $display("FAIL fwft_empty_n3 got=%b exp=0", bus.empty); else n_pass++;
        bus.re = 1'b1;
        @(negedge clk);
        bus.re = 1'b0;
        n_checks++; if (bus.dvld !== 1'b0) $display("FAIL fwft_dvld_pop got=%b exp=0", bus.dvld); else n_pass++;
        n_checks++; if (bus.empty !== 1'b1) $display("FAIL fwft_empty_pop got=%b exp=1", bus.empty); else n_pass++;
        n_checks++; if (bus.underflow !== 1'b0) $display("FAIL fwft_uflow_pop got=%b exp=0", bus.underflow); else n_pass++;
        bus.wptr_gray_sync = gray(4);
        repeat (3) @(negedge clk);
        bus.re = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (bus.dvld !== 1'b1) $display("FAIL fwft_b2b_dvld[%0d] got=%b exp=1", k, bus.dvld); else n_pass++;
            @(negedge clk);
        end
        bus.re = 1'b0;
        n_checks++; if (bus.dvld !== 1'b0) $display("FAIL fwft_b2b_end got=%b exp=0", bus.dvld); else n_pass++;
        n_checks++; if (bus.rd_count !== 4'd0) $display("FAIL fwft_b2b_count got=%0d exp=0", bus.rd_count); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
`ifndef COREFIFO_RD_FWFT_EN
        test_fill_drain();
        test_wrap();
        test_underflow();
        test_reset_mid();
`else
        test_fwft();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
